// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DefWordLen   = 32;
  localparam int unsigned DefWordCount = 16;
  localparam int unsigned NumRead      = 3;
  localparam int unsigned NumWrite     = 2;

  // Index width for a register count; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-through select: port 0 write beats port 1 write beats stored value.
module regfile_bypass_mux #(
  parameter int unsigned WordLen = 32,
  parameter int unsigned AddrW   = 4
) (
  input  logic [AddrW-1:0]   raddr_i,
  input  logic [WordLen-1:0] stored_i,
  input  logic               we0_i,
  input  logic [AddrW-1:0]   waddr0_i,
  input  logic [WordLen-1:0] wdata0_i,
  input  logic               we1_i,
  input  logic [AddrW-1:0]   waddr1_i,
  input  logic [WordLen-1:0] wdata1_i,
  output logic [WordLen-1:0] rdata_o
);

  always_comb begin
    rdata_o = stored_i;
    if (we0_i && (waddr0_i == raddr_i)) begin
      rdata_o = wdata0_i;
    end else if (we1_i && (waddr1_i == raddr_i)) begin
      rdata_o = wdata1_i;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Dual-write, triple-read register file with bypass and a per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WORD_LEN   = DefWordLen,
  parameter int unsigned WORD_COUNT = DefWordCount,
  localparam int unsigned AW        = addr_width(WORD_COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr0,
  input  logic [AW-1:0]       waddr1,
  input  logic [WORD_LEN-1:0] wdata0,
  input  logic [WORD_LEN-1:0] wdata1,
  input  logic [AW-1:0]       raddr0,
  input  logic [AW-1:0]       raddr1,
  input  logic [AW-1:0]       raddr2,
  output logic [WORD_LEN-1:0] rdata0,
  output logic [WORD_LEN-1:0] rdata1,
  output logic [WORD_LEN-1:0] rdata2,
  output logic                busy0,
  output logic                busy1,
  output logic                busy2,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                flush,
  output logic [AW:0]         pending_cnt
);

  logic [WORD_LEN-1:0]   regs_q [WORD_COUNT];
  logic [WORD_LEN-1:0]   regs_d [WORD_COUNT];
  logic [WORD_COUNT-1:0] pend_q, pend_d;
  logic [AW:0]           cnt_q, cnt_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < WORD_COUNT;
  endfunction

  logic [NumWrite-1:0] we_v;
  logic                issue_v;
  assign we_v    = {we1 & in_range(waddr1), we0 & in_range(waddr0)};
  assign issue_v = issue_en & in_range(issue_addr);

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < WORD_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (we_v[1] && (waddr1 == AW'(i))) begin
        regs_d[i] = wdata1;
        pend_d[i] = 1'b0;
      end
      if (we_v[0] && (waddr0 == AW'(i))) begin
        regs_d[i] = wdata0;
        pend_d[i] = 1'b0;
      end
      // Issue after the write clear so a new producer keeps the bit set.
      if (issue_v && (issue_addr == AW'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  logic inc, dec0, dec1;
  assign inc  = issue_v && !pend_q[issue_addr];
  assign dec0 = we_v[0] && pend_q[waddr0] && !(issue_v && (issue_addr == waddr0));
  // Port 1 hitting the same index as port 0 is the same bit, counted once.
  assign dec1 = we_v[1] && pend_q[waddr1] && !(issue_v && (issue_addr == waddr1))
                && !(we_v[0] && (waddr0 == waddr1));

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  logic [AW-1:0]       raddr [NumRead];
  logic [WORD_LEN-1:0] rdata [NumRead];
  logic [NumRead-1:0]  busy;

  assign raddr[0] = raddr0;
  assign raddr[1] = raddr1;
  assign raddr[2] = raddr2;

  for (genvar p = 0; p < NumRead; p++) begin : g_rd
    logic                ok, wr_hit, iss_hit;
    logic [WORD_LEN-1:0] stored;

    assign ok      = in_range(raddr[p]);
    assign stored  = ok ? regs_q[raddr[p]] : '0;
    assign wr_hit  = (we_v[0] && (waddr0 == raddr[p])) || (we_v[1] && (waddr1 == raddr[p]));
    assign iss_hit = issue_v && (issue_addr == raddr[p]);
    assign busy[p] = ok && ((pend_q[raddr[p]] && !wr_hit) || iss_hit);

    regfile_bypass_mux #(
      .WordLen (WORD_LEN),
      .AddrW   (AW)
    ) u_bypass (
      .raddr_i  (raddr[p]),
      .stored_i (stored),
      .we0_i    (we_v[0]),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .we1_i    (we_v[1]),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .rdata_o  (rdata[p])
    );
  end

  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
  assign rdata2 = rdata[2];
  assign busy0  = busy[0];
  assign busy1  = busy[1];
  assign busy2  = busy[2];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

  localparam int unsigned WL = 32;
  localparam int unsigned AW = 4;

  logic          clk, rst;
  logic          we0, we1, issue_en, flush;
  logic [AW-1:0] waddr0, waddr1, raddr0, raddr1, raddr2, issue_addr;
  logic [WL-1:0] wdata0, wdata1, rdata0, rdata1, rdata2;
  logic          busy0, busy1, busy2;
  logic [AW:0]   pending_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .we0         (we0),
    .we1         (we1),
    .waddr0      (waddr0),
    .waddr1      (waddr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .raddr0      (raddr0),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .busy0       (busy0),
    .busy1       (busy1),
    .busy2       (busy2),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; issue_en = 0; flush = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; issue_addr = 0;
  endtask

  // Advance one edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    raddr0 = 0; raddr1 = 0; raddr2 = 0;
    rst = 1;
    #2;
    check("rst_rdata0", rdata0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_cnt", pending_cnt, 0);
    step();
    step();
    rst = 0;
    #1;

    for (int i = 0; i < 16; i++) begin
      raddr0 = AW'(i); raddr1 = AW'(i); raddr2 = AW'(i);
      #1;
      check($sformatf("init_r%0d_d0", i), rdata0, 0);
      check($sformatf("init_r%0d_d2", i), rdata2, 0);
      check($sformatf("init_r%0d_b1", i), {busy0, busy1, busy2}, 0);
    end
    check("init_cnt", pending_cnt, 0);

    // Same-index dual write: port 0 wins.
    step();
    we0 = 1; waddr0 = 3; wdata0 = 32'h11;
    we1 = 1; waddr1 = 3; wdata1 = 32'h22;
    raddr0 = 3;
    #1;
    check("dual_wr_bypass", rdata0, 32'h11);
    step();
    idle();
    #1;
    check("dual_wr_stored", rdata0, 32'h11);

    // Port 1 bypass on read port 2.
    we1 = 1; waddr1 = 5; wdata1 = 32'hDEADBEEF; raddr2 = 5;
    #1;
    check("p1_bypass", rdata2, 32'hDEADBEEF);
    step();
    idle();
    #1;
    check("p1_stored", rdata2, 32'hDEADBEEF);

    // Scoreboard on r7.
    raddr1 = 7;
    issue_en = 1; issue_addr = 7;
    #1;
    check("issue_same_cycle_busy", busy1, 1);
    step();
    idle();
    #1;
    check("issue_busy", busy1, 1);
    check("issue_cnt", pending_cnt, 1);
    we0 = 1; waddr0 = 7; wdata0 = 32'h5;
    #1;
    check("wr_masks_busy", busy1, 0);
    check("wr_bypass_r7", rdata1, 32'h5);
    step();
    idle();
    #1;
    check("wr_clear_busy", busy1, 0);
    check("wr_clear_cnt", pending_cnt, 0);
    check("wr_r7_stored", rdata1, 32'h5);
    issue_en = 1; issue_addr = 7; we0 = 1; waddr0 = 7; wdata0 = 32'h6;
    #1;
    check("iss_wr_busy_cyc", busy1, 1);
    step();
    idle();
    #1;
    check("iss_wr_busy", busy1, 1);
    check("iss_wr_cnt", pending_cnt, 1);
    check("iss_wr_data", rdata1, 32'h6);
    we0 = 1; waddr0 = 7; wdata0 = 32'h7;
    step();
    idle();
    #1;
    check("r7_drain_cnt", pending_cnt, 0);

    // Re-issue of a pending index, then two distinct clears in one cycle.
    issue_en = 1; issue_addr = 10;
    step();
    step();
    idle();
    #1;
    check("reissue_cnt", pending_cnt, 1);
    issue_en = 1; issue_addr = 11;
    step();
    idle();
    #1;
    check("two_pending_cnt", pending_cnt, 2);
    we0 = 1; waddr0 = 10; we1 = 1; waddr1 = 11;
    step();
    idle();
    #1;
    check("dual_clear_cnt", pending_cnt, 0);

    // Both ports writing one pending index clear it once.
    issue_en = 1; issue_addr = 12;
    step();
    idle();
    we0 = 1; waddr0 = 12; we1 = 1; waddr1 = 12;
    step();
    idle();
    #1;
    check("same_idx_clear_cnt", pending_cnt, 0);

    // Flush overriding a same-cycle issue.
    issue_en = 1; issue_addr = 1;
    step();
    issue_addr = 2;
    step();
    issue_addr = 4;
    step();
    idle();
    raddr0 = 1; raddr1 = 2; raddr2 = 4;
    #1;
    check("pre_flush_cnt", pending_cnt, 3);
    check("pre_flush_busy", {busy0, busy1, busy2}, 3'b111);
    flush = 1; issue_en = 1; issue_addr = 9;
    step();
    idle();
    #1;
    check("flush_cnt", pending_cnt, 0);
    check("flush_busy", {busy0, busy1, busy2}, 0);
    raddr0 = 9;
    #1;
    check("flush_r9_busy", busy0, 0);

    // Reset during an in-flight write and issue.
    raddr0 = 6; raddr1 = 3;
    we0 = 1; waddr0 = 6; wdata0 = 32'h99; issue_en = 1; issue_addr = 6;
    #1;
    rst = 1;
    step();
    idle();
    rst = 0;
    #1;
    step();
    check("rst_mid_r6", rdata0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_cnt", pending_cnt, 0);
    check("rst_mid_r3", rdata1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
